// File: rtl/snitch_operand_fetch.sv
// -----------------------------------------------------------------------------
// snitch_operand_fetch
//
// Read-side companion to the Snitch latch register file. Accepts one
// instruction's source-register addresses, spreads the reads over the
// register file's limited read ports across one or more cycles, and holds
// back any operand whose register still has an outstanding write in the
// scoreboard. Once every operand is collected, the bundle is offered to the
// execute stage through a valid/ready handshake.
//
// Ports:
//   clk_i        clock
//   rst_ni       synchronous, active-low reset
//   req_valid_i  request valid
//   req_ready_o  request accepted when valid & ready (only in IDLE)
//   req_raddr_i  NR_OPERANDS source register addresses
//   req_ren_i    NR_OPERANDS operand-used mask
//   busy_i       per-register scoreboard, 1 = outstanding write
//   rf_raddr_o   NR_READ_PORTS register file read addresses
//   rf_rdata_i   NR_READ_PORTS read data, combinational in the same cycle
//   rsp_valid_o  operand bundle valid
//   rsp_ready_i  consumer ready
//   rsp_data_o   NR_OPERANDS collected operands
//   wb_valid_i, wb_addr_i, wb_data_i
//                write-back forward port, only when SNITCH_OPFETCH_FORWARD_EN
//                is defined
//
// Build option:
//   SNITCH_OPFETCH_FORWARD_EN  a busy pending operand captures matching
//                              write-back data instead of waiting for the
//                              scoreboard to clear. Without it, busy
//                              operands simply wait.
// -----------------------------------------------------------------------------
module snitch_operand_fetch #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDR_WIDTH    = 5,
    parameter int unsigned NR_READ_PORTS = 2,
    parameter int unsigned NR_OPERANDS   = 3,
    parameter bit          ZERO_REG_ZERO = 1'b1
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic                                      req_valid_i,
    output logic                                      req_ready_o,
    input  logic [NR_OPERANDS-1:0][ADDR_WIDTH-1:0]    req_raddr_i,
    input  logic [NR_OPERANDS-1:0]                    req_ren_i,
    input  logic [(2**ADDR_WIDTH)-1:0]                busy_i,
    output logic [NR_READ_PORTS-1:0][ADDR_WIDTH-1:0]  rf_raddr_o,
    input  logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]  rf_rdata_i,
    output logic                                      rsp_valid_o,
    input  logic                                      rsp_ready_i,
    output logic [NR_OPERANDS-1:0][DATA_WIDTH-1:0]    rsp_data_o
`ifdef SNITCH_OPFETCH_FORWARD_EN
    ,
    input  logic                                      wb_valid_i,
    input  logic [ADDR_WIDTH-1:0]                     wb_addr_i,
    input  logic [DATA_WIDTH-1:0]                     wb_data_i
`endif
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] OUT     = 2'd2;

    localparam int unsigned PORT_IDX_W = (NR_READ_PORTS > 1) ? $clog2(NR_READ_PORTS) : 1;

    logic [1:0]                                  state_q, state_d;
    logic [NR_OPERANDS-1:0][ADDR_WIDTH-1:0]      addr_q;
    logic [NR_OPERANDS-1:0]                      pending_q, pending_d;
    logic [NR_OPERANDS-1:0][DATA_WIDTH-1:0]      operand_q, operand_d;
    logic [NR_OPERANDS-1:0]                      grant;
    logic [NR_OPERANDS-1:0]                      fwd;
    logic [NR_OPERANDS-1:0]                      accept_zero;
    logic [NR_OPERANDS-1:0][DATA_WIDTH-1:0]      read_data;
    logic [NR_READ_PORTS-1:0][ADDR_WIDTH-1:0]    rf_raddr;
    logic [DATA_WIDTH-1:0]                       fwd_data;
    logic                                        accept;

    // Handshake outputs are held low during reset so nothing leaks out
    // before the state register has been initialised.
    assign req_ready_o = rst_ni && (state_q == IDLE);
    assign rsp_valid_o = rst_ni && (state_q == OUT);
    assign rsp_data_o  = operand_q;
    assign rf_raddr_o  = rst_ni ? rf_raddr : '0;
    assign accept      = req_valid_i && req_ready_o;

    // Operands addressing the hard-wired zero register never need a port.
    always_comb begin
        accept_zero = '0;
        for (int i = 0; i < NR_OPERANDS; i++) begin
            accept_zero[i] = ZERO_REG_ZERO && (req_raddr_i[i] == '0);
        end
    end

    // Port scheduler: walk operands lowest index first and hand out read
    // ports in ascending order to pending operands whose register is free.
    // A busy operand is skipped, so later operands can be read around it.
    always_comb begin
        int unsigned slot;
        slot      = 0;
        grant     = '0;
        rf_raddr  = '0;
        read_data = '0;
        if (state_q == COLLECT) begin
            for (int i = 0; i < NR_OPERANDS; i++) begin
                if (pending_q[i] && !busy_i[addr_q[i]] && (slot < NR_READ_PORTS)) begin
                    grant[i]                       = 1'b1;
                    rf_raddr[PORT_IDX_W'(slot)]    = addr_q[i];
                    read_data[i]                   = rf_rdata_i[PORT_IDX_W'(slot)];
                    slot                           = slot + 1;
                end
            end
        end
    end

    // Write-back forwarding: every busy pending operand whose address matches
    // the write-back captures it at once, without taking a read port.
`ifdef SNITCH_OPFETCH_FORWARD_EN
    always_comb begin
        fwd      = '0;
        fwd_data = wb_data_i;
        for (int i = 0; i < NR_OPERANDS; i++) begin
            fwd[i] = (state_q == COLLECT) && pending_q[i] && busy_i[addr_q[i]]
                     && wb_valid_i && (wb_addr_i == addr_q[i]);
        end
    end
`else
    always_comb begin
        fwd      = '0;
        fwd_data = '0;
    end
`endif

    // Next-state logic for the IDLE -> COLLECT -> OUT sequence.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        operand_d = operand_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    for (int i = 0; i < NR_OPERANDS; i++) begin
                        pending_d[i] = req_ren_i[i] && !accept_zero[i];
                        if (!pending_d[i]) begin
                            operand_d[i] = '0;
                        end
                    end
                    state_d = (pending_d == '0) ? OUT : COLLECT;
                end
            end
            COLLECT: begin
                for (int i = 0; i < NR_OPERANDS; i++) begin
                    if (grant[i]) begin
                        operand_d[i] = read_data[i];
                        pending_d[i] = 1'b0;
                    end else if (fwd[i]) begin
                        operand_d[i] = fwd_data;
                        pending_d[i] = 1'b0;
                    end
                end
                if (pending_d == '0) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; a reset mid-operation simply drops the request.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            pending_q <= '0;
            operand_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            operand_q <= operand_d;
            if (accept) begin
                addr_q <= req_raddr_i;
            end
        end
    end

endmodule

// File: tb/tb_snitch_operand_fetch.sv
// -----------------------------------------------------------------------------
// tb_snitch_operand_fetch
//
// Self-checking bench for snitch_operand_fetch with 2 read ports and 3
// operands. A behavioural register file answers reads combinationally; each
// accepted request pushes its expected bundle and latency onto a scoreboard
// queue, which is popped when the response appears.
// -----------------------------------------------------------------------------
module tb_snitch_operand_fetch;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NP   = 2;
    localparam int NO   = 3;
    localparam int NREG = 32;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       req_valid;
    logic                       req_ready;
    logic [NO-1:0][AW-1:0]      req_raddr;
    logic [NO-1:0]              req_ren;
    logic [NREG-1:0]            busy;
    logic [NP-1:0][AW-1:0]      rf_raddr;
    logic [NP-1:0][DW-1:0]      rf_rdata;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [NO-1:0][DW-1:0]      rsp_data;
`ifdef SNITCH_OPFETCH_FORWARD_EN
    logic                       wb_valid;
    logic [AW-1:0]              wb_addr;
    logic [DW-1:0]              wb_data;
`endif

    typedef struct {
        logic [NO-1:0][DW-1:0] data;
        int                    lat;
    } exp_t;

    exp_t sb[$];
    int   n_compared = 0;
    int   n_mismatch = 0;

    always #5 clk = ~clk;

    snitch_operand_fetch #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .NR_READ_PORTS (NP),
        .NR_OPERANDS   (NO),
        .ZERO_REG_ZERO (1'b1)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_raddr_i (req_raddr),
        .req_ren_i   (req_ren),
        .busy_i      (busy),
        .rf_raddr_o  (rf_raddr),
        .rf_rdata_i  (rf_rdata),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data)
`ifdef SNITCH_OPFETCH_FORWARD_EN
        ,
        .wb_valid_i  (wb_valid),
        .wb_addr_i   (wb_addr),
        .wb_data_i   (wb_data)
`endif
    );

    // Register file contents: xN holds N*0x11, x0 holds a poison value so a
    // port read of x0 is visible in the data.
    function automatic logic [DW-1:0] rf_val(input logic [AW-1:0] a);
        return (a == '0) ? 32'hBAD0_0000 : 32'(a) * 32'h11;
    endfunction

    always_comb begin
        for (int p = 0; p < NP; p++) begin
            rf_rdata[p] = rf_val(rf_raddr[p]);
        end
    end

    // Reference model of one request with every register free.
    function automatic exp_t model(input logic [NO-1:0][AW-1:0] addrs, input logic [NO-1:0] ren);
        exp_t e;
        int   n = 0;
        for (int i = 0; i < NO; i++) begin
            if (ren[i] && addrs[i] != '0) begin
                e.data[i] = rf_val(addrs[i]);
                n++;
            end else begin
                e.data[i] = '0;
            end
        end
        e.lat = (n == 0) ? 1 : 1 + (n + NP - 1) / NP;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request for a single edge; returns one cycle after accept.
    task automatic applyStimulus(input logic [NO-1:0][AW-1:0] addrs, input logic [NO-1:0] ren);
        req_valid = 1'b1;
        req_raddr = addrs;
        req_ren   = ren;
        tick();
        req_valid = 1'b0;
    endtask

    // Waits (bounded) for rsp_valid; cyc counts cycles since the accept edge.
    task automatic wait_rsp(input int start, output int cyc);
        cyc = start;
        while (rsp_valid !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    task automatic complete_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_raddr = '0;
        req_ren   = '0;
        busy      = '0;
        rsp_ready = 1'b0;
`ifdef SNITCH_OPFETCH_FORWARD_EN
        wb_valid  = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
`endif
        tick();
        tick();
        n_compared++;
        if (rsp_valid !== 1'b0) begin
            n_mismatch++;
            $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid);
        end
        n_compared++;
        if (req_ready !== 1'b0) begin
            n_mismatch++;
            $display("[TB] FAIL reset_req_ready: got %b expected 0", req_ready);
        end
        n_compared++;
        if (rf_raddr !== '0) begin
            n_mismatch++;
            $display("[TB] FAIL reset_rf_raddr: got %h expected 0", rf_raddr);
        end
        rst_n = 1'b1;
        #1;
        n_compared++;
        if (req_ready !== 1'b1) begin
            n_mismatch++;
            $display("[TB] FAIL reset_idle_ready: got %b expected 1", req_ready);
        end
        n_compared++;
        if (rsp_data !== '0) begin
            n_mismatch++;
            $display("[TB] FAIL reset_rsp_data: got %h expected 0", rsp_data);
        end
    endtask

    task automatic test_three_operands();
        exp_t e;
        int   cyc;
        e = model({5'd7, 5'd6, 5'd5}, 3'b111);
        sb.push_back(e);
        applyStimulus({5'd7, 5'd6, 5'd5}, 3'b111);
        n_compared++;
        if (rf_raddr !== {5'd6, 5'd5}) begin
            n_mismatch++;
            $display("[TB] FAIL three_ports_c1: got %h expected %h", rf_raddr, {5'd6, 5'd5});
        end
        tick();
        n_compared++;
        if (rf_raddr !== {5'd0, 5'd7}) begin
            n_mismatch++;
            $display("[TB] FAIL three_ports_c2: got %h expected %h", rf_raddr, {5'd0, 5'd7});
        end
        wait_rsp(2, cyc);
        e = sb.pop_front();
        n_compared++;
        if (rsp_valid !== 1'b1 || cyc != e.lat) begin
            n_mismatch++;
            $display("[TB] FAIL three_latency: got %0d (valid %b) expected %0d", cyc, rsp_valid, e.lat);
        end
        n_compared++;
        if (rsp_data !== e.data || e.data !== {32'h77, 32'h66, 32'h55}) begin
            n_mismatch++;
            $display("[TB] FAIL three_data: got %h expected %h", rsp_data, e.data);
        end
        complete_rsp();
    endtask

    task automatic test_zero_reg();
        exp_t e;
        int   cyc;
        busy[0] = 1'b1;
        e = model({5'd0, 5'd3, 5'd0}, 3'b011);
        sb.push_back(e);
        applyStimulus({5'd0, 5'd3, 5'd0}, 3'b011);
        n_compared++;
        if (rf_raddr !== {5'd0, 5'd3}) begin
            n_mismatch++;
            $display("[TB] FAIL zero_ports: got %h expected %h", rf_raddr, {5'd0, 5'd3});
        end
        wait_rsp(1, cyc);
        e = sb.pop_front();
        n_compared++;
        if (rsp_valid !== 1'b1 || cyc != e.lat) begin
            n_mismatch++;
            $display("[TB] FAIL zero_latency: got %0d (valid %b) expected %0d", cyc, rsp_valid, e.lat);
        end
        n_compared++;
        if (rsp_data !== e.data) begin
            n_mismatch++;
            $display("[TB] FAIL zero_data: got %h expected %h", rsp_data, e.data);
        end
        complete_rsp();
        busy[0] = 1'b0;
    endtask

    task automatic test_busy_bypass();
        exp_t e;
        int   cyc;
        busy[4] = 1'b1;
        e = model({5'd0, 5'd9, 5'd4}, 3'b011);
        e.lat = 4;
        sb.push_back(e);
        applyStimulus({5'd0, 5'd9, 5'd4}, 3'b011);
        n_compared++;
        if (rf_raddr !== {5'd0, 5'd9}) begin
            n_mismatch++;
            $display("[TB] FAIL busy_ports_c1: got %h expected %h", rf_raddr, {5'd0, 5'd9});
        end
        tick();
        n_compared++;
        if (rf_raddr !== '0 || rsp_valid !== 1'b0) begin
            n_mismatch++;
            $display("[TB] FAIL busy_stall_c2: got ports %h valid %b expected ports 0 valid 0", rf_raddr, rsp_valid);
        end
        tick();
        busy[4] = 1'b0;
        #1;
        n_compared++;
        if (rf_raddr !== {5'd0, 5'd4}) begin
            n_mismatch++;
            $display("[TB] FAIL busy_ports_c3: got %h expected %h", rf_raddr, {5'd0, 5'd4});
        end
        wait_rsp(3, cyc);
        e = sb.pop_front();
        n_compared++;
        if (rsp_valid !== 1'b1 || cyc != e.lat) begin
            n_mismatch++;
            $display("[TB] FAIL busy_latency: got %0d (valid %b) expected %0d", cyc, rsp_valid, e.lat);
        end
        n_compared++;
        if (rsp_data !== e.data) begin
            n_mismatch++;
            $display("[TB] FAIL busy_data: got %h expected %h", rsp_data, e.data);
        end
        complete_rsp();
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   cyc;
        e = model({5'd3, 5'd2, 5'd1}, 3'b111);
        sb.push_back(e);
        applyStimulus({5'd3, 5'd2, 5'd1}, 3'b111);
        wait_rsp(1, cyc);
        e = sb.pop_front();
        n_compared++;
        if (rsp_valid !== 1'b1 || cyc != e.lat) begin
            n_mismatch++;
            $display("[TB] FAIL bp_latency: got %0d (valid %b) expected %0d", cyc, rsp_valid, e.lat);
        end
        for (int k = 0; k < 5; k++) begin
            n_compared++;
            if (rsp_valid !== 1'b1 || rsp_data !== e.data || req_ready !== 1'b0) begin
                n_mismatch++;
                $display("[TB] FAIL bp_hold_%0d: got valid %b data %h ready %b expected valid 1 data %h ready 0",
                         k, rsp_valid, rsp_data, req_ready, e.data);
            end
            tick();
        end
        complete_rsp();
        n_compared++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_mismatch++;
            $display("[TB] FAIL bp_release: got valid %b ready %b expected valid 0 ready 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_zero_operands();
        exp_t e;
        int   cyc;
        e = model({5'd7, 5'd6, 5'd5}, 3'b000);
        sb.push_back(e);
        applyStimulus({5'd7, 5'd6, 5'd5}, 3'b000);
        wait_rsp(1, cyc);
        e = sb.pop_front();
        n_compared++;
        if (rsp_valid !== 1'b1 || cyc != e.lat || rsp_data !== e.data) begin
            n_mismatch++;
            $display("[TB] FAIL noren: got lat %0d data %h expected lat %0d data %h", cyc, rsp_data, e.lat, e.data);
        end
        complete_rsp();
        e = model({5'd0, 5'd0, 5'd0}, 3'b111);
        sb.push_back(e);
        applyStimulus({5'd0, 5'd0, 5'd0}, 3'b111);
        wait_rsp(1, cyc);
        e = sb.pop_front();
        n_compared++;
        if (rsp_valid !== 1'b1 || cyc != e.lat || rsp_data !== e.data) begin
            n_mismatch++;
            $display("[TB] FAIL all_x0: got lat %0d data %h expected lat %0d data %h", cyc, rsp_data, e.lat, e.data);
        end
        complete_rsp();
    endtask

    task automatic test_reset_mid();
        logic seen;
        busy[10] = 1'b1;
        busy[11] = 1'b1;
        busy[12] = 1'b1;
        sb.push_back(model({5'd12, 5'd11, 5'd10}, 3'b111));
        applyStimulus({5'd12, 5'd11, 5'd10}, 3'b111);
        tick();
        rst_n = 1'b0;
        tick();
        sb.delete();
        n_compared++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            n_mismatch++;
            $display("[TB] FAIL midreset_outputs: got valid %b ready %b expected 0 0", rsp_valid, req_ready);
        end
        rst_n = 1'b1;
        busy  = '0;
        seen  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            seen = seen | (rsp_valid !== 1'b0);
        end
        n_compared++;
        if (seen !== 1'b0 || req_ready !== 1'b1) begin
            n_mismatch++;
            $display("[TB] FAIL midreset_no_rsp: got spurious %b ready %b expected 0 1", seen, req_ready);
        end
    endtask

    task automatic test_back_to_back();
        exp_t                  e;
        int                    cyc;
        logic [NO-1:0][AW-1:0] addrs;
        logic [NO-1:0]         ren;
        for (int it = 0; it < 16; it++) begin
            for (int i = 0; i < NO; i++) begin
                addrs[i] = AW'($urandom_range(0, NREG - 1));
            end
            ren = NO'($urandom_range(0, 7));
            sb.push_back(model(addrs, ren));
            applyStimulus(addrs, ren);
            wait_rsp(1, cyc);
            e = sb.pop_front();
            n_compared++;
            if (rsp_valid !== 1'b1 || cyc != e.lat || rsp_data !== e.data) begin
                n_mismatch++;
                $display("[TB] FAIL b2b_%0d: got lat %0d data %h expected lat %0d data %h",
                         it, cyc, rsp_data, e.lat, e.data);
            end
            complete_rsp();
        end
    endtask

`ifdef SNITCH_OPFETCH_FORWARD_EN
    task automatic test_forward();
        exp_t e;
        int   cyc;
        busy[8] = 1'b1;
        e = model({5'd0, 5'd0, 5'd8}, 3'b001);
        e.data[0] = 32'h0000_DEAD;
        e.lat     = 2;
        sb.push_back(e);
        applyStimulus({5'd0, 5'd0, 5'd8}, 3'b001);
        wb_valid = 1'b1;
        wb_addr  = 5'd8;
        wb_data  = 32'h0000_DEAD;
        #1;
        n_compared++;
        if (rf_raddr !== '0) begin
            n_mismatch++;
            $display("[TB] FAIL fwd_ports: got %h expected 0", rf_raddr);
        end
        tick();
        wb_valid = 1'b0;
        busy[8]  = 1'b0;
        wait_rsp(2, cyc);
        e = sb.pop_front();
        n_compared++;
        if (rsp_valid !== 1'b1 || cyc != e.lat || rsp_data !== e.data) begin
            n_mismatch++;
            $display("[TB] FAIL fwd_rsp: got lat %0d data %h expected lat %0d data %h", cyc, rsp_data, e.lat, e.data);
        end
        complete_rsp();
    endtask
`endif

    initial begin
        test_reset();
        test_three_operands();
        test_zero_reg();
        test_busy_bypass();
        test_backpressure();
        test_zero_operands();
        test_reset_mid();
        test_back_to_back();
`ifdef SNITCH_OPFETCH_FORWARD_EN
        test_forward();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
